// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - shared CSR addresses, mstatus fields and FSM encoding for trap_sequencer
package trap_sequencer_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      E_EPC    = 3'd1,
      E_CAUSE  = 3'd2,
      E_STATUS = 3'd3,
      M_STATUS = 3'd4,
      JUMP     = 3'd5
   } state_t;

   typedef enum logic {
      TRAP_MRET  = 1'b0,
      TRAP_ECALL = 1'b1
   } trap_kind_t;

endpackage

// File: rtl/trap_sequencer_mstatus_update.sv
// rtl/trap_sequencer_mstatus_update.sv - combinational mstatus read-modify-write for trap entry and mret
module mstatus_update
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] old_status,
   input  trap_kind_t      trap_kind,
   output logic [XLEN-1:0] new_status
);

   always_comb begin
      new_status = old_status;
      // Only M-mode exists, so MPP is pinned to 2'b11 on both entry and return.
      new_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      if (trap_kind == TRAP_ECALL) begin
         new_status[MSTATUS_MPIE] = old_status[MSTATUS_MIE];
         new_status[MSTATUS_MIE]  = 1'b0;
      end else begin
         new_status[MSTATUS_MIE]  = old_status[MSTATUS_MPIE];
         new_status[MSTATUS_MPIE] = 1'b1;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - write-back trap sequencer: ecall/mret CSR updates, stall, flush and redirect
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              CSR_AW      = 12,
   parameter logic [XLEN-1:0] ECALL_CAUSE = 32'hB
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic              W_valid_i,
   input  logic              W_ecall_i,
   input  logic              W_mret_i,
   input  logic [XLEN-1:0]   W_pc_i,
   input  logic              W_csr_we_i,
   input  logic [CSR_AW-1:0] W_csr_addr_i,
   input  logic [XLEN-1:0]   W_csr_wdata_i,
   input  logic [XLEN-1:0]   csr_rdata_i,
   output logic [CSR_AW-1:0] csr_raddr_o,
   output logic              csr_we_o,
   output logic [CSR_AW-1:0] csr_waddr_o,
   output logic [XLEN-1:0]   csr_wdata_o,
   output logic              stall_o,
   output logic              flush_o,
   output logic              redirect_valid_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic              busy_o
);

   state_t            state_q;
   state_t            state_d;
   logic [XLEN-1:0]   epc_q;
   trap_kind_t        kind_q;
   logic              take_ecall;
   logic              take_mret;
   logic [XLEN-1:0]   status_next;

   // ecall wins when both trap flags arrive together.
   assign take_ecall = (state_q == IDLE) && W_valid_i && W_ecall_i;
   assign take_mret  = (state_q == IDLE) && W_valid_i && W_mret_i && !W_ecall_i;
   assign busy_o     = (state_q != IDLE);

   mstatus_update #(
      .XLEN(XLEN)
   ) u_mstatus_update (
      .old_status (csr_rdata_i),
      .trap_kind  (kind_q),
      .new_status (status_next)
   );

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         epc_q   <= '0;
         kind_q  <= TRAP_MRET;
      end else begin
         state_q <= state_d;
         if (take_ecall) begin
            epc_q  <= W_pc_i;
            kind_q <= TRAP_ECALL;
         end else if (take_mret) begin
            kind_q <= TRAP_MRET;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (take_ecall) begin
               state_d = E_EPC;
            end else if (take_mret) begin
               state_d = M_STATUS;
            end
         end
         E_EPC:    state_d = E_CAUSE;
         E_CAUSE:  state_d = E_STATUS;
         E_STATUS: state_d = JUMP;
         M_STATUS: state_d = JUMP;
         JUMP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      csr_raddr_o      = CSR_AW'(CSR_MSTATUS);
      csr_we_o         = 1'b0;
      csr_waddr_o      = W_csr_addr_i;
      csr_wdata_o      = W_csr_wdata_i;
      stall_o          = 1'b0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      case (state_q)
         IDLE: begin
            if (take_ecall || take_mret) begin
               stall_o = 1'b1;
            end else begin
               csr_we_o = W_csr_we_i & W_valid_i;
            end
         end
         E_EPC: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_AW'(CSR_MEPC);
            csr_wdata_o = epc_q;
         end
         E_CAUSE: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_AW'(CSR_MCAUSE);
            csr_wdata_o = ECALL_CAUSE;
         end
         E_STATUS, M_STATUS: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_AW'(CSR_MSTATUS);
            csr_wdata_o = status_next;
         end
         JUMP: begin
            // Target comes from mtvec on entry or mepc on return, forced to 4-byte alignment.
            csr_raddr_o      = (kind_q == TRAP_ECALL) ? CSR_AW'(CSR_MTVEC) : CSR_AW'(CSR_MEPC);
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = {csr_rdata_i[XLEN-1:2], 2'b00};
         end
         default: begin
            csr_we_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        W_valid, W_ecall, W_mret, W_csr_we;
   logic [31:0] W_pc, W_csr_wdata;
   logic [11:0] W_csr_addr;
   logic [31:0] csr_rdata;
   logic [11:0] csr_raddr_o, csr_waddr_o;
   logic        csr_we_o, stall_o, flush_o, redirect_valid_o, busy_o;
   logic [31:0] csr_wdata_o, redirect_pc_o;

   logic [31:0] csr_mem [0:4095];
   int          redir_cnt = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   trap_sequencer #(
      .XLEN(32), .CSR_AW(12), .ECALL_CAUSE(32'hB)
   ) dut (
      .clk_i            (clk),
      .rst              (rst),
      .W_valid_i        (W_valid),
      .W_ecall_i        (W_ecall),
      .W_mret_i         (W_mret),
      .W_pc_i           (W_pc),
      .W_csr_we_i       (W_csr_we),
      .W_csr_addr_i     (W_csr_addr),
      .W_csr_wdata_i    (W_csr_wdata),
      .csr_rdata_i      (csr_rdata),
      .csr_raddr_o      (csr_raddr_o),
      .csr_we_o         (csr_we_o),
      .csr_waddr_o      (csr_waddr_o),
      .csr_wdata_o      (csr_wdata_o),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .busy_o           (busy_o)
   );

   assign csr_rdata = csr_mem[csr_raddr_o];

   always @(posedge clk) begin
      if (csr_we_o) csr_mem[csr_waddr_o] <= csr_wdata_o;
      if (redirect_valid_o) redir_cnt <= redir_cnt + 1;
   end

   task automatic idle_inputs();
      W_valid = 0; W_ecall = 0; W_mret = 0; W_pc = '0;
      W_csr_we = 0; W_csr_addr = '0; W_csr_wdata = '0;
   endtask

   task automatic csr_setup(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      idle_inputs();
      W_valid = 1; W_csr_we = 1; W_csr_addr = a; W_csr_wdata = d;
      @(negedge clk);
      idle_inputs();
   endtask

   // Drives one ecall and checks every cycle through JUMP; trap and CSR inputs stay asserted to prove they are ignored.
   task automatic run_ecall(input logic [31:0] pc, input logic both, input logic [31:0] exp_status, input string tag);
      @(negedge clk);
      W_valid = 1; W_ecall = 1; W_mret = both; W_pc = pc;
      W_csr_we = 1; W_csr_addr = 12'h7C0; W_csr_wdata = 32'hDEADBEEF;
      #1;
      checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL %s_c0_stall got=%h exp=1", tag, stall_o); end
      checks++; if (csr_we_o !== 1'b0) begin failures++; $display("FAIL %s_c0_we_suppressed got=%h exp=0", tag, csr_we_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL %s_c0_busy got=%h exp=0", tag, busy_o); end
      @(negedge clk);
      W_pc = 32'h11111110;
      #1;
      checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h341 || csr_wdata_o !== pc) begin failures++;
         $display("FAIL %s_mepc_write got=%h/%h/%h exp=1/341/%h", tag, csr_we_o, csr_waddr_o, csr_wdata_o, pc); end
      checks++; if (stall_o !== 1'b1 || busy_o !== 1'b1 || csr_raddr_o !== 12'h300) begin failures++;
         $display("FAIL %s_c1_ctrl got=%h/%h/%h exp=1/1/300", tag, stall_o, busy_o, csr_raddr_o); end
      @(negedge clk); #1;
      checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h342 || csr_wdata_o !== 32'hB || stall_o !== 1'b1) begin failures++;
         $display("FAIL %s_mcause_write got=%h/%h/%h/%h exp=1/342/0000000b/1", tag, csr_we_o, csr_waddr_o, csr_wdata_o, stall_o); end
      @(negedge clk); #1;
      checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h300 || csr_wdata_o !== exp_status || stall_o !== 1'b1) begin failures++;
         $display("FAIL %s_mstatus_write got=%h/%h/%h/%h exp=1/300/%h/1", tag, csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, exp_status); end
      @(negedge clk); #1;
      checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h80000100) begin failures++;
         $display("FAIL %s_redirect got=%h/%h exp=1/80000100", tag, redirect_valid_o, redirect_pc_o); end
      checks++; if (flush_o !== 1'b1 || stall_o !== 1'b0 || csr_we_o !== 1'b0 || csr_raddr_o !== 12'h305) begin failures++;
         $display("FAIL %s_jump_ctrl got=%h/%h/%h/%h exp=1/0/0/305", tag, flush_o, stall_o, csr_we_o, csr_raddr_o); end
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      @(negedge clk); #1;
      checks++; if ({stall_o, flush_o, redirect_valid_o, busy_o, csr_we_o} !== 5'b0) begin failures++;
         $display("FAIL reset_outputs got=%b exp=00000", {stall_o, flush_o, redirect_valid_o, busy_o, csr_we_o}); end
      checks++; if (csr_raddr_o !== 12'h300) begin failures++; $display("FAIL reset_raddr got=%h exp=300", csr_raddr_o); end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_csr_forward();
      @(negedge clk);
      idle_inputs();
      W_valid = 1; W_csr_we = 1; W_csr_addr = 12'h305; W_csr_wdata = 32'h80000200;
      #1;
      checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h305 || csr_wdata_o !== 32'h80000200) begin failures++;
         $display("FAIL fwd_write got=%h/%h/%h exp=1/305/80000200", csr_we_o, csr_waddr_o, csr_wdata_o); end
      checks++; if (stall_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%h/%h exp=0/0", stall_o, busy_o); end
      @(negedge clk);
      W_valid = 0;
      #1;
      checks++; if (csr_we_o !== 1'b0) begin failures++; $display("FAIL fwd_invalid_we got=%h exp=0", csr_we_o); end
      checks++; if (csr_mem[12'h305] !== 32'h80000200) begin failures++; $display("FAIL fwd_mem got=%h exp=80000200", csr_mem[12'h305]); end
      idle_inputs();
   endtask

   task automatic test_ecall();
      csr_setup(12'h305, 32'h80000101);
      csr_setup(12'h300, 32'h00001808);
      run_ecall(32'h80000010, 1'b0, 32'h00001880, "ecall");
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (busy_o !== 1'b0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin failures++;
         $display("FAIL ecall_after_idle got=%h/%h/%h exp=0/0/0", busy_o, stall_o, flush_o); end
      checks++; if (csr_mem[12'h341] !== 32'h80000010 || csr_mem[12'h342] !== 32'hB || csr_mem[12'h300] !== 32'h1880) begin failures++;
         $display("FAIL ecall_mem got=%h/%h/%h exp=80000010/0000000b/00001880", csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]); end
   endtask

   task automatic test_mret();
      csr_setup(12'h341, 32'h80000014);
      @(negedge clk);
      W_valid = 1; W_mret = 1;
      #1;
      checks++; if (stall_o !== 1'b1 || csr_we_o !== 1'b0 || busy_o !== 1'b0) begin failures++;
         $display("FAIL mret_c0 got=%h/%h/%h exp=1/0/0", stall_o, csr_we_o, busy_o); end
      @(negedge clk); #1;
      checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h300 || csr_wdata_o !== 32'h1888 || stall_o !== 1'b1) begin failures++;
         $display("FAIL mret_mstatus got=%h/%h/%h/%h exp=1/300/00001888/1", csr_we_o, csr_waddr_o, csr_wdata_o, stall_o); end
      @(negedge clk); #1;
      checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h80000014 || csr_raddr_o !== 12'h341 || flush_o !== 1'b1) begin failures++;
         $display("FAIL mret_redirect got=%h/%h/%h/%h exp=1/80000014/341/1", redirect_valid_o, redirect_pc_o, csr_raddr_o, flush_o); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (csr_mem[12'h300] !== 32'h1888 || busy_o !== 1'b0) begin failures++;
         $display("FAIL mret_done got=%h/%h exp=00001888/0", csr_mem[12'h300], busy_o); end
   endtask

   task automatic test_priority();
      run_ecall(32'h80000020, 1'b1, 32'h00001880, "prio");
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (csr_mem[12'h341] !== 32'h80000020 || csr_mem[12'h300] !== 32'h1880) begin failures++;
         $display("FAIL prio_mem got=%h/%h exp=80000020/00001880", csr_mem[12'h341], csr_mem[12'h300]); end
   endtask

   task automatic test_back_to_back();
      int r0;
      r0 = redir_cnt;
      run_ecall(32'h80000030, 1'b0, 32'h00001800, "b2b_first");
      run_ecall(32'h80000040, 1'b0, 32'h00001800, "b2b_second");
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (csr_mem[12'h341] !== 32'h80000040 || redir_cnt - r0 !== 2) begin failures++;
         $display("FAIL b2b_result got=%h/%0d exp=80000040/2", csr_mem[12'h341], redir_cnt - r0); end
   endtask

   task automatic test_reset_mid();
      int r0;
      csr_setup(12'h342, 32'h12345678);
      csr_setup(12'h300, 32'h00001808);
      r0 = redir_cnt;
      @(negedge clk);
      W_valid = 1; W_ecall = 1; W_pc = 32'h80000050;
      @(negedge clk);
      idle_inputs();
      @(negedge clk); #1;
      checks++; if (csr_waddr_o !== 12'h342 || busy_o !== 1'b1) begin failures++;
         $display("FAIL rstmid_in_cause got=%h/%h exp=342/1", csr_waddr_o, busy_o); end
      rst = 1;
      #1;
      checks++; if ({busy_o, stall_o, csr_we_o, redirect_valid_o, flush_o} !== 5'b0) begin failures++;
         $display("FAIL rstmid_async got=%b exp=00000", {busy_o, stall_o, csr_we_o, redirect_valid_o, flush_o}); end
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (4) @(negedge clk);
      #1;
      checks++; if (csr_mem[12'h342] !== 32'h12345678 || csr_mem[12'h300] !== 32'h1808) begin failures++;
         $display("FAIL rstmid_no_write got=%h/%h exp=12345678/00001808", csr_mem[12'h342], csr_mem[12'h300]); end
      checks++; if (redir_cnt !== r0 || busy_o !== 1'b0) begin failures++;
         $display("FAIL rstmid_no_redirect got=%0d/%h exp=%0d/0", redir_cnt, busy_o, r0); end
   endtask

   initial begin
      test_reset();
      test_csr_forward();
      test_ecall();
      test_mret();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The block SHALL have parameters: XLEN, 32, datapath width; CSR_AW, 12, CSR address width; ECALL_CAUSE, 32'hB, mcause value for M-mode ecall.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk_i  in  1  single clock, all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- W_valid_i  in  1  instruction present in write-back.
- W_ecall_i  in  1  write-back instruction is ecall.
- W_mret_i  in  1  write-back instruction is mret.
- W_pc_i  in  XLEN  PC of the write-back instruction.
- W_csr_we_i  in  1  ordinary CSR instruction write request.
- W_csr_addr_i  in  CSR_AW  ordinary CSR write address.
- W_csr_wdata_i  in  XLEN  ordinary CSR write data.
- csr_rdata_i  in  XLEN  combinational CSR file read data for csr_raddr_o.
- csr_raddr_o  out  CSR_AW  CSR file read address.
- csr_we_o  out  1  CSR file write enable.
- csr_waddr_o  out  CSR_AW  CSR file write address.
- csr_wdata_o  out  XLEN  CSR file write data.
- stall_o  out  1  freeze fetch through write-back.
- flush_o  out  1  kill all younger in-flight instructions.
- redirect_valid_o  out  1  fetch PC override strobe.
- redirect_pc_o  out  XLEN  new fetch PC.
- busy_o  out  1  FSM not in IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, E_EPC, E_CAUSE, E_STATUS, M_STATUS, JUMP.
REQ-004 In IDLE with W_valid_i and W_ecall_i, the block SHALL latch W_pc_i, set a trap-kind flag to ecall, assert stall_o combinationally, and go to E_EPC.
REQ-005 In IDLE with W_valid_i, W_mret_i and not W_ecall_i, the block SHALL set trap-kind to mret, assert stall_o, and go to M_STATUS.
REQ-006 If W_ecall_i and W_mret_i are both high, ecall SHALL take priority.
REQ-007 In IDLE without an accepted trap, csr_we_o/addr/wdata SHALL forward W_csr_we_i&W_valid_i, W_csr_addr_i, W_csr_wdata_i unchanged; stall_o low.
REQ-008 On the cycle a trap is accepted, the ordinary CSR write SHALL be suppressed (csr_we_o=0).
REQ-009 E_EPC SHALL write 0x341 with the latched PC; E_CAUSE SHALL write 0x342 with ECALL_CAUSE.
REQ-010 E_STATUS SHALL read 0x300 and write it back with bit7(MPIE)=old bit3(MIE), bit3=0, bits12:11(MPP)=2'b11, other bits unchanged.
REQ-011 M_STATUS SHALL read 0x300 and write it back with bit3=old bit7, bit7=1, bits12:11=2'b11, other bits unchanged.
REQ-012 JUMP SHALL drive csr_raddr_o=0x305 (ecall) or 0x341 (mret), csr_we_o=0, redirect_valid_o=1, flush_o=1, redirect_pc_o=csr_rdata_i with bits1:0 cleared, then return to IDLE.
REQ-013 stall_o SHALL be high in every state except IDLE and JUMP; in JUMP flush_o supersedes stall.
REQ-014 Latency: ecall redirect SHALL occur exactly 4 cycles after acceptance; mret redirect exactly 2 cycles after acceptance.
REQ-015 Trap inputs SHALL be ignored in all non-IDLE states; a new trap is acceptable in the IDLE cycle immediately following JUMP.
REQ-016 csr_raddr_o SHALL be 0x300 in IDLE, E_EPC, E_CAUSE, E_STATUS, M_STATUS.

Reset
REQ-017 Asserting rst SHALL asynchronously force state=IDLE, latched PC=0, trap-kind=0; outputs then equal IDLE values (stall_o, flush_o, redirect_valid_o, busy_o = 0).
REQ-018 Reset mid-sequence SHALL abandon the sequence with no further CSR writes or redirect.

Structure
REQ-019 CSR addresses (0x300, 0x305, 0x341, 0x342), mstatus bit positions, and the FSM state encoding SHALL live in the shared define package.
REQ-020 The mstatus read-modify-write SHALL be a combinational sub-module mstatus_update (inputs old value, trap-kind; output new value).

Verification
REQ-021 ecall at W_pc_i=0x80000010, mstatus=0x1808, mtvec=0x80000101 -> writes mepc=0x80000010, mcause=0xB, mstatus=0x1880; redirect_pc_o=0x80000100 at cycle 4.
REQ-022 mret with mepc=0x80000014, mstatus=0x1880 -> mstatus=0x1888; redirect_pc_o=0x80000014 at cycle 2.
REQ-023 ecall and mret high together -> ecall sequence only, mret ignored.
REQ-024 Ordinary CSR write to 0x305 data 0x80000200 in IDLE -> forwarded same cycle, stall_o=0.
REQ-025 rst asserted in E_CAUSE -> immediate IDLE, no mcause/mstatus write, no redirect.
REQ-026 Back-to-back ecall presented in cycle after JUMP -> accepted, second full sequence completes.
